// File: rtl/conv_mem_responder.sv
// Memory responder and run controller for the convolution engine: bank 0 holds
// image/weights/bias (M0 port), bank 1 holds the result map (M1 port).
module conv_mem_responder #(
    parameter int IN_WORDS  = 794,
    parameter int OUT_WORDS = 676
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M0_R_req,
    input  logic [31:0] M0_addr,
    input  logic [3:0]  M0_W_req,
    input  logic [31:0] M0_W_data,
    output logic [31:0] M0_R_data,
    input  logic        M1_R_req,
    input  logic [31:0] M1_addr,
    input  logic [3:0]  M1_W_req,
    input  logic [31:0] M1_W_data,
    output logic [31:0] M1_R_data,
    output logic        start,
    input  logic        finish,
    input  logic        host_we,
    input  logic        host_bank,
    input  logic [9:0]  host_addr,
    input  logic [31:0] host_wdata,
    input  logic        host_re,
    output logic [31:0] host_rdata,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic        addr_err,
    output logic [31:0] run_cycles
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_next;

    logic [31:0] bank0 [IN_WORDS];
    logic [31:0] bank1 [OUT_WORDS];

    logic [9:0]  m0_idx;
    logic [9:0]  m1_idx;
    logic        m0_ok;
    logic        m1_ok;
    logic        m0_wr;
    logic        m1_wr;
    logic        m0_rd;
    logic        m1_rd;
    logic        host_en;
    logic        host_ok;
    logic        host_wr;
    logic        host_rd;
    logic        access_err;
    logic        unused_addr_bits;

    // Range is judged on the full word index; only the low 10 bits address the arrays.
    assign m0_idx = M0_addr[11:2];
    assign m1_idx = M1_addr[11:2];
    assign m0_ok  = M0_addr[31:2] < 30'(IN_WORDS);
    assign m1_ok  = M1_addr[31:2] < 30'(OUT_WORDS);
    assign m0_wr  = |M0_W_req;
    assign m1_wr  = |M1_W_req;
    assign m0_rd  = M0_R_req && !m0_wr;
    assign m1_rd  = M1_R_req && !m1_wr;

    assign host_en = (state == S_IDLE) || (state == S_DONE);
    assign host_ok = host_bank ? (host_addr < 10'(OUT_WORDS)) : (host_addr < 10'(IN_WORDS));
    assign host_wr = host_en && host_we;
    assign host_rd = host_en && host_re;

    assign access_err = ((m0_wr || m0_rd) && !m0_ok) ||
                        ((m1_wr || m1_rd) && !m1_ok) ||
                        ((host_wr || host_rd) && !host_ok);

    assign unused_addr_bits = ^{M0_addr[1:0], M1_addr[1:0]};

    // NOTE: the memory arrays have no reset; clearing them would forbid RAM inference and lose preloaded data.
    always_ff @(posedge clk) begin
        if (m0_wr && m0_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (M0_W_req[k]) bank0[m0_idx][8*k +: 8] <= M0_W_data[8*k +: 8];
            end
        end
        if (host_wr && !host_bank && host_ok) bank0[host_addr] <= host_wdata;
    end

    always_ff @(posedge clk) begin
        if (m1_wr && m1_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (M1_W_req[k]) bank1[m1_idx][8*k +: 8] <= M1_W_data[8*k +: 8];
            end
        end
        if (host_wr && host_bank && host_ok) bank1[host_addr] <= host_wdata;
    end

    // Read data registers hold between accepted reads; the engine samples late.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M0_R_data  <= '0;
            M1_R_data  <= '0;
            host_rdata <= '0;
            addr_err   <= 1'b0;
        end else begin
            if (m0_rd) begin
                if (m0_ok) M0_R_data <= bank0[m0_idx];
                else       M0_R_data <= '0;
            end
            if (m1_rd) begin
                if (m1_ok) M1_R_data <= bank1[m1_idx];
                else       M1_R_data <= '0;
            end
            if (host_rd) begin
                if (!host_ok)       host_rdata <= '0;
                else if (host_bank) host_rdata <= bank1[host_addr];
                else                host_rdata <= bank0[host_addr];
            end
            if (access_err) addr_err <= 1'b1;
        end
    end

    // NOTE: the default assignment comes first so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (go && !finish) state_next = S_START;
            S_START:        state_next = S_RUN;
            S_RUN:          if (finish) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            run_cycles <= '0;
        end else begin
            state <= state_next;
            if (state == S_START) begin
                run_cycles <= '0;
            end else if (state == S_RUN && run_cycles != 32'hFFFF_FFFF) begin
                run_cycles <= run_cycles + 32'd1;
            end
        end
    end

    assign start = (state == S_START);
    assign busy  = (state == S_START) || (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed bench for conv_mem_responder; a behavioural convolution engine
// drives the M0/M1 ports for the full-run scenario.
module tb_conv_mem_responder;

    logic        clk;
    logic        rst;
    logic        M0_R_req;
    logic [31:0] M0_addr;
    logic [3:0]  M0_W_req;
    logic [31:0] M0_W_data;
    logic [31:0] M0_R_data;
    logic        M1_R_req;
    logic [31:0] M1_addr;
    logic [3:0]  M1_W_req;
    logic [31:0] M1_W_data;
    logic [31:0] M1_R_data;
    logic        start;
    logic        finish;
    logic        host_we;
    logic        host_bank;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_re;
    logic [31:0] host_rdata;
    logic        go;
    logic        busy;
    logic        done;
    logic        addr_err;
    logic [31:0] run_cycles;

    int errors;
    int checks;
    int start_seen;

    conv_mem_responder dut (
        .clk(clk), .rst(rst),
        .M0_R_req(M0_R_req), .M0_addr(M0_addr), .M0_W_req(M0_W_req),
        .M0_W_data(M0_W_data), .M0_R_data(M0_R_data),
        .M1_R_req(M1_R_req), .M1_addr(M1_addr), .M1_W_req(M1_W_req),
        .M1_W_data(M1_W_data), .M1_R_data(M1_R_data),
        .start(start), .finish(finish),
        .host_we(host_we), .host_bank(host_bank), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_re(host_re), .host_rdata(host_rdata),
        .go(go), .busy(busy), .done(done), .addr_err(addr_err),
        .run_cycles(run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (start === 1'b1) start_seen++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All helpers start and end at a falling edge.
    task automatic host_write(input logic bank, input logic [9:0] addr, input logic [31:0] data);
        host_we = 1'b1; host_bank = bank; host_addr = addr; host_wdata = data;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic bank, input logic [9:0] addr, output logic [31:0] data);
        host_re = 1'b1; host_bank = bank; host_addr = addr;
        @(negedge clk);
        host_re = 1'b0;
        data = host_rdata;
    endtask

    task automatic m0_read(input logic [31:0] addr, output logic [31:0] data);
        M0_R_req = 1'b1; M0_addr = addr;
        @(negedge clk);
        M0_R_req = 1'b0;
        data = M0_R_data;
    endtask

    task automatic m1_read(input logic [31:0] addr, output logic [31:0] data);
        M1_R_req = 1'b1; M1_addr = addr;
        @(negedge clk);
        M1_R_req = 1'b0;
        data = M1_R_data;
    endtask

    task automatic m1_write(input logic [31:0] addr, input logic [3:0] lanes, input logic [31:0] data);
        M1_W_req = lanes; M1_addr = addr; M1_W_data = data;
        @(negedge clk);
        M1_W_req = 4'b0000;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        host_write(1'b0, 10'd5, 32'h1234_5678);
        host_read(1'b0, 10'd5, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++; $display("FAIL reset_pre_rdata: got %h expected %h", d, 32'h1234_5678);
        end
        pulse_go();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL reset_pre_busy: got %b expected 1", busy);
        end
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (host_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_host_rdata: got %h expected 0", host_rdata);
        end
        checks++;
        if (run_cycles !== 32'h0) begin
            errors++; $display("FAIL reset_run_cycles: got %h expected 0", run_cycles);
        end
        checks++;
        if ({start, done, addr_err, M0_R_data, M1_R_data} !== 67'h0) begin
            errors++;
            $display("FAIL reset_others: got start=%b done=%b addr_err=%b m0=%h m1=%h expected all 0",
                     start, done, addr_err, M0_R_data, M1_R_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_hold();
        logic [31:0] d;
        host_write(1'b0, 10'd793, 32'h0001_0000);
        m0_read(32'hC64, d);
        checks++;
        if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL read_hold_first: got %h expected %h", d, 32'h0001_0000);
        end
        M0_addr = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (M0_R_data !== 32'h0001_0000) begin
                errors++; $display("FAIL read_hold_cycle%0d: got %h expected %h", i, M0_R_data, 32'h0001_0000);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        host_write(1'b1, 10'd2, 32'h1122_3344);
        m1_read(32'h8, d);
        checks++;
        if (d !== 32'h1122_3344) begin
            errors++; $display("FAIL lanes_initial: got %h expected %h", d, 32'h1122_3344);
        end
        M1_R_req = 1'b1;
        m1_write(32'h8, 4'b0011, 32'hAABB_CCDD);
        M1_R_req = 1'b0;
        checks++;
        if (M1_R_data !== 32'h1122_3344) begin
            errors++; $display("FAIL lanes_rdata_unchanged: got %h expected %h", M1_R_data, 32'h1122_3344);
        end
        m1_read(32'h8, d);
        checks++;
        if (d !== 32'h1122_CCDD) begin
            errors++; $display("FAIL lanes_merged: got %h expected %h", d, 32'h1122_CCDD);
        end
    endtask

    task automatic test_range();
        logic [31:0] d;
        checks++;
        if (addr_err !== 1'b0) begin
            errors++; $display("FAIL range_pre_err: got %b expected 0", addr_err);
        end
        m0_read(32'hC68, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL range_rdata: got %h expected 0", d);
        end
        checks++;
        if (addr_err !== 1'b1) begin
            errors++; $display("FAIL range_err_set: got %b expected 1", addr_err);
        end
        m0_read(32'hC64, d);
        checks++;
        if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL range_valid_read: got %h expected %h", d, 32'h0001_0000);
        end
        checks++;
        if (addr_err !== 1'b1) begin
            errors++; $display("FAIL range_err_sticky: got %b expected 1", addr_err);
        end
    endtask

    // Behavioural engine: 3x3 valid convolution in Q16.16 over the 28x28 image.
    task automatic run_engine();
        logic [31:0] w [9];
        logic [31:0] bias;
        logic [31:0] pix;
        logic [31:0] acc;
        logic [63:0] prod;
        for (int k = 0; k < 9; k++) m0_read(32'(4 * (784 + k)), w[k]);
        m0_read(32'(4 * 793), bias);
        for (int r = 0; r < 26; r++) begin
            for (int c = 0; c < 26; c++) begin
                acc = bias;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        m0_read(32'(4 * ((r + i) * 28 + c + j)), pix);
                        prod = 64'(pix) * 64'(w[i * 3 + j]);
                        acc  = acc + prod[47:16];
                    end
                end
                m1_write(32'(4 * (r * 26 + c)), 4'hF, acc);
            end
        end
    endtask

    task automatic test_full_run();
        logic [31:0] d;
        logic [31:0] first_bad;
        int bad;
        for (int i = 0; i < 794; i++) host_write(1'b0, 10'(i), (i == 793) ? 32'h0 : 32'h0001_0000);
        start_seen = 0;
        pulse_go();
        checks++;
        if (start !== 1'b1) begin
            errors++; $display("FAIL run_start_high: got %b expected 1", start);
        end
        run_engine();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL run_done_early: got %b expected 0", done);
        end
        finish = 1'b1;
        for (int n = 0; n < 8 && done !== 1'b1; n++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL run_done_rise: got %b expected 1 within 8 cycles", done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL run_busy_clear: got %b expected 0", busy);
        end
        checks++;
        if (start_seen != 1) begin
            errors++; $display("FAIL run_start_cycles: got %0d expected 1", start_seen);
        end
        checks++;
        if (run_cycles <= 32'd676) begin
            errors++; $display("FAIL run_cycles_min: got %0d expected > 676", run_cycles);
        end
        bad = 0;
        first_bad = 32'h0;
        for (int i = 0; i < 676; i++) begin
            host_read(1'b1, 10'(i), d);
            if (d !== 32'h0009_0000) begin
                if (bad == 0) first_bad = d;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL run_drain: %0d words wrong, first got %h expected %h", bad, first_bad, 32'h0009_0000);
        end
    endtask

    task automatic test_run_restrictions();
        logic [31:0] d;
        int seen0;
        seen0 = start_seen;
        pulse_go();
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL go_ignored_state: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        checks++;
        if (start_seen != seen0) begin
            errors++; $display("FAIL go_ignored_start: got %0d pulses expected %0d", start_seen, seen0);
        end
        finish = 1'b0;
        pulse_go();
        checks++;
        if (start !== 1'b1) begin
            errors++; $display("FAIL rerun_start: got %b expected 1", start);
        end
        @(negedge clk);
        host_write(1'b0, 10'd0, 32'hDEAD_BEEF);
        host_read(1'b0, 10'd0, d);
        checks++;
        if (d !== 32'h0009_0000) begin
            errors++; $display("FAIL run_host_rdata_hold: got %h expected %h", d, 32'h0009_0000);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL run_busy: got %b expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, start} !== 3'b000) begin
            errors++; $display("FAIL midrun_reset_state: got busy=%b done=%b start=%b expected 000", busy, done, start);
        end
        checks++;
        if (addr_err !== 1'b0) begin
            errors++; $display("FAIL midrun_reset_err: got %b expected 0", addr_err);
        end
        @(negedge clk);
        rst = 1'b0;
        host_read(1'b0, 10'd0, d);
        checks++;
        if (d !== 32'h0001_0000) begin
            errors++; $display("FAIL run_write_dropped: got %h expected %h", d, 32'h0001_0000);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        start_seen = 0;
        rst = 1'b1;
        M0_R_req = 1'b0; M0_addr = '0; M0_W_req = '0; M0_W_data = '0;
        M1_R_req = 1'b0; M1_addr = '0; M1_W_req = '0; M1_W_data = '0;
        finish = 1'b0; go = 1'b0;
        host_we = 1'b0; host_bank = 1'b0; host_addr = '0; host_wdata = '0; host_re = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_read_hold();
        test_byte_lanes();
        test_range();
        test_full_run();
        test_run_restrictions();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_mem_responder.md
# conv_mem_responder

Memory responder and run controller on the far side of the convolution engine's two memory master ports. Holds the 28x28 input image plus 3x3 weights and bias (bank 0, served on the M0 port) and the 26x26 result map (bank 1, served on the M1 port). A host-side port preloads bank 0 and drains bank 1. A small FSM issues the engine's one-cycle `start` pulse and detects completion via `finish`.

## Interface
- `IN_WORDS`, 794, bank 0 depth in 32-bit words: image at 0..783, weights at 784..792, bias at 793.
- `OUT_WORDS`, 676, bank 1 depth in 32-bit words.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `M0_R_req` in 1: bank 0 read request.
- `M0_addr` in 32: bank 0 byte address; word index = `addr[31:2]`, `addr[1:0]` ignored.
- `M0_W_req` in 4: bank 0 byte-lane write enables.
- `M0_W_data` in 32: bank 0 write data.
- `M0_R_data` out 32: bank 0 read data.
- `M1_R_req`, `M1_addr`, `M1_W_req`, `M1_W_data`, `M1_R_data`: same as the M0 signals, for bank 1.
- `start` out 1: single-cycle run pulse to the engine.
- `finish` in 1: engine completion; once high, it stays high until the engine is reset.
- `host_we` in 1: host write strobe.
- `host_bank` in 1: host bank select (0 or 1).
- `host_addr` in 10: host word index.
- `host_wdata` in 32: host write data.
- `host_re` in 1: host read strobe.
- `host_rdata` out 32: host read data.
- `go` in 1: host run request.
- `busy` out 1: high in START and RUN.
- `done` out 1: high in DONE.
- `addr_err` out 1: sticky out-of-range flag.
- `run_cycles` out 32: cycle count of the last or current run.

## Operation
- FSM states are IDLE, START, RUN, DONE. Reset state is IDLE.
  - IDLE: on `go`=1 with `finish`=0, go to START. A `go` while `finish`=1 is ignored.
  - START: `start`=1 for exactly this one cycle. Clear `run_cycles`. Go to RUN.
  - RUN: increment `run_cycles` each cycle (saturates at 0xFFFFFFFF). Go to DONE on the first cycle `finish`=1.
  - DONE: `done`=1. A `go` is accepted only if `finish`=0, which then leads to START.
- Engine ports M0/M1 are serviced in every state. The host port is serviced in IDLE and DONE only.
- In START and RUN, host writes are dropped and `host_rdata` holds its value.
- Write precedence on an engine port: `W_req`≠0 is a write and takes priority over `R_req` in the same cycle.
  - For each lane k with `W_req[k]`=1, write byte `W_data[8k+7:8k]` at the clock edge. Other lanes are preserved.
  - `R_data` is unchanged in a write cycle.
- Engine read: `R_req`=1 and `W_req`=0 at edge N gives `R_data` = mem[index] registered at edge N.
  - `R_data` holds until the next accepted read, because the engine samples one or two cycles late.
  - `R_req` held high re-reads every cycle at the current address.
- Out-of-range access (word index ≥ bank depth): reads return 0, writes are dropped, `addr_err` is set. `addr_err` is cleared only by `rst`.
- Host port:
  - `host_we` writes the full word to bank `host_bank`.
  - `host_re` registers mem[`host_addr`] into `host_rdata` (1-cycle latency).
  - Simultaneous `host_we` and `host_re`: the write is performed and `host_rdata` returns the old data.
  - Host out-of-range accesses behave as on the engine ports.
- Memory arrays are not reset.

## Timing
- Reset values (asynchronous, immediate): `start`, `busy`, `done`, `addr_err` = 0; `M0_R_data`, `M1_R_data`, `host_rdata`, `run_cycles` = 0; state IDLE.
- Engine read latency is 1 cycle; write latency is 0 (data visible to a read in the next cycle).
- `go` sampled at edge N in IDLE gives `start`=1 in cycle N+1 and `busy`=1 from cycle N+1.
- `finish` sampled high at edge M in RUN gives `done`=1 and `busy`=0 from cycle M+1. `run_cycles` freezes at its value after edge M.
- `rst` asserted mid-RUN: state returns to IDLE immediately and memory contents are retained. Engine-port writes still land in the reset-release cycle.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs 0 immediately, with no clock edge needed.
- Read hold: host writes bank0[793]=0x00010000. M0 `R_req`=1, `addr`=0xC64 for one cycle → `M0_R_data`=0x00010000 next cycle. It holds for 3 more idle cycles.
- Byte lanes: bank1[2]=0x11223344. M1 `W_req`=4'b0011, `addr`=0x8, `W_data`=0xAABBCCDD with `R_req`=1 → `M1_R_data` unchanged. A following read of `addr` 0x8 returns 0x1122CCDD.
- Range: M0 read at `addr`=0xC68 (word 794) → `M0_R_data`=0, `addr_err`=1. A following valid read leaves `addr_err` at 1.
- Full run with the convolution engine attached:
  - Stimulus: image and weights all 0x00010000, bias 0; pulse `go`.
  - `start` is high for exactly 1 cycle.
  - `done` rises after `finish`.
  - All 676 bank1 words read 0x00090000 via the host port.
  - `run_cycles` > 676.
- Host write in RUN to bank0[0] is dropped, as is `go` while `finish`=1. Then `rst` mid-RUN → IDLE, `busy`=0, and bank0[0] reads back its preloaded value.
